memory_arbiter: RTL and testbench

Single-port RAM arbiter between the instruction-fetch and data-access request paths of the CPU. The request unit drives iREN and dREN/dWEN toward this block. The arbiter grants one requester at a time, registers the winning request, drives the shared RAM, and returns a one-cycle hit with the loaded word. It sits between the request unit and the RAM model, and it also enforces halt and a RAM-response timeout.

---
 rtl/memory_arbiter_if.sv | 35 +++
 rtl/memory_arbiter.sv | 143 ++++++++++++++
 tb/tb_memory_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// Request-path and RAM-path bundle for memory_arbiter.
//   slave  : arbiter side. It takes the CPU requests and the RAM response, and drives hits, loads and RAM controls.
//   master : environment side (request unit plus RAM model).
// Signals:
//   iREN/iaddr -> ihit/iload                  instruction fetch
//   dREN/dWEN/daddr/dstore -> dhit/dload      data access
//   ramREN/ramWEN/ramaddr/ramstore <- ramload/ramready   shared RAM
interface memory_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between the instruction-fetch and data-access paths.
// Data requests have strict priority. The winning request is registered and
// driven to the RAM, and a one-cycle hit is returned. The block also handles
// halt and a RAM-response timeout.
// Ports:
//   CLK, nRST    clock; asynchronous active-low reset
//   halt         CPU halt; takes effect from IDLE or after DONE
//   busy         access in progress (not IDLE, not HALTED)
//   timeout_err  sticky timeout flag, cleared only by reset
//   bus          memory_arbiter_if.slave (request and RAM signals)
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a request; data beats halt beats instruction
// GRANT_D  | data access on the RAM, waiting for ramready or timeout
// GRANT_I  | instruction read on the RAM, waiting for ramready or timeout
// DONE     | hit pulse; requester turnaround, requests ignored
// HALTED   | absorbing; only reset leaves it
module memory_arbiter #(
    parameter int          TIMEOUT = 255,
    parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              halt,
    output logic              busy,
    output logic              timeout_err,
    memory_arbiter_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_GRANT_D, S_GRANT_I, S_DONE, S_HALTED
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_q, store_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ihit_q, ihit_d;
    logic        dhit_q, dhit_d;
    logic [31:0] iload_q, iload_d;
    logic [31:0] dload_q, dload_d;
    logic        terr_q, terr_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
            cnt_q   <= '0;
            ihit_q  <= 1'b0;
            dhit_q  <= 1'b0;
            iload_q <= '0;
            dload_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            cnt_q   <= cnt_d;
            ihit_q  <= ihit_d;
            dhit_q  <= dhit_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        store_d = store_q;
        cnt_d   = cnt_q;
        ihit_d  = 1'b0;
        dhit_d  = 1'b0;
        iload_d = iload_q;
        dload_d = dload_q;
        terr_d  = terr_q;

        case (state_q)
            S_IDLE: begin
                // A pending data request wins over halt so it is not lost.
                if (bus.dREN || bus.dWEN) begin
                    state_d = S_GRANT_D;
                    wr_d    = bus.dWEN;
                    addr_d  = bus.daddr;
                    store_d = bus.dstore;
                    cnt_d   = '0;
                end else if (halt) begin
                    state_d = S_HALTED;
                end else if (bus.iREN) begin
                    state_d = S_GRANT_I;
                    wr_d    = 1'b0;
                    addr_d  = bus.iaddr;
                    cnt_d   = '0;
                end
            end
            S_GRANT_D, S_GRANT_I: begin
                if (bus.ramready) begin
                    state_d = S_DONE;
                    if (state_q == S_GRANT_I) begin
                        ihit_d  = 1'b1;
                        iload_d = bus.ramload;
                    end else begin
                        dhit_d = 1'b1;
                        if (!wr_q) dload_d = bus.ramload;
                    end
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d = S_DONE;
                    terr_d  = 1'b1;
                    if (state_q == S_GRANT_I) begin
                        ihit_d  = 1'b1;
                        iload_d = ERRWORD;
                    end else begin
                        dhit_d  = 1'b1;
                        dload_d = ERRWORD;
                    end
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE:   state_d = halt ? S_HALTED : S_IDLE;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    assign bus.ramREN   = (state_q == S_GRANT_I) || ((state_q == S_GRANT_D) && !wr_q);
    assign bus.ramWEN   = (state_q == S_GRANT_D) && wr_q;
    assign bus.ramaddr  = addr_q;
    assign bus.ramstore = store_q;
    assign bus.ihit     = ihit_q;
    assign bus.iload    = iload_q;
    assign bus.dhit     = dhit_q;
    assign bus.dload    = dload_q;
    assign busy         = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign timeout_err  = terr_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter. It uses a table of directed accesses,
// randomized access pairs checked against a timeline/memory reference model,
// and hand sequences for reset, timeout and halt.
module tb_memory_arbiter;
    logic CLK = 1'b0;
    logic nRST;
    logic halt;
    logic busy;
    logic timeout_err;

    memory_arbiter_if bus_if();

    memory_arbiter #(.TIMEOUT(4), .ERRWORD(32'hBAD1BAD1)) dut (
        .CLK(CLK), .nRST(nRST), .halt(halt), .busy(busy),
        .timeout_err(timeout_err), .bus(bus_if.slave)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int  wait_q[$];
    bit  in_grant = 0;
    bit  ram_dead = 0;
    int  gidx = 0;
    int  cur_wait = 0;
    logic [31:0] model_dload;

    typedef struct {
        bit ir; bit dr; bit dw;
        logic [31:0] ia; logic [31:0] da; logic [31:0] ds;
        int wd; int wi; int hd; int hi;
        logic [31:0] il; logic [31:0] dl;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : (a ^ 32'hA5A5_0000);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'hA5A5_0000);
    endfunction

    // RAM behaviour for the current cycle; called just after each rising edge.
    task automatic ram_step();
        if (bus_if.ramREN || bus_if.ramWEN) begin
            if (!in_grant) begin
                in_grant = 1;
                gidx     = 0;
                cur_wait = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
            end
            if (!ram_dead && gidx == cur_wait) begin
                bus_if.ramready = 1'b1;
                if (bus_if.ramWEN) ram_mem[bus_if.ramaddr] = bus_if.ramstore;
                bus_if.ramload = bus_if.ramREN ? ram_rd(bus_if.ramaddr) : $urandom;
                in_grant = 0;
            end else begin
                bus_if.ramready = 1'b0;
                bus_if.ramload  = $urandom;
            end
            gidx++;
        end else begin
            in_grant        = 0;
            bus_if.ramready = ram_dead ? 1'b0 : 1'($urandom_range(0, 1));
            bus_if.ramload  = $urandom;
        end
    endtask

    task automatic drop_reqs();
        bus_if.iREN = 1'b0;
        bus_if.dREN = 1'b0;
        bus_if.dWEN = 1'b0;
    endtask

    // Requests raised in cycle 0; hd/hi are the expected hit cycles (-1: none).
    task automatic run_case(input string nm, input bit ir, input bit dr, input bit dw,
                            input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                            input int wd, input int wi, input int hd, input int hi,
                            input logic [31:0] il, input logic [31:0] dl);
        int  last;
        int  ds_s;
        int  is_s;
        bit  in_d;
        bit  in_i;
        wait_q.delete();
        if (dr || dw) wait_q.push_back(wd);
        if (ir) wait_q.push_back(wi);
        last = (hi >= 0) ? hi : hd;
        ds_s = hd - 1 - wd;
        is_s = hi - 1 - wi;
        @(posedge CLK); #1;
        bus_if.iREN = ir; bus_if.iaddr = ia;
        bus_if.dREN = dr; bus_if.dWEN = dw; bus_if.daddr = da; bus_if.dstore = ds;
        for (int c = 0; c <= last + 1; c++) begin
            if (c > 0) begin
                @(posedge CLK); #1;
            end
            if (bus_if.dhit) begin
                bus_if.dREN = 1'b0;
                bus_if.dWEN = 1'b0;
            end
            if (bus_if.ihit) bus_if.iREN = 1'b0;
            ram_step();
            @(negedge CLK);
            in_d = (hd >= 0) && (c >= ds_s) && (c <= hd - 1);
            in_i = (hi >= 0) && (c >= is_s) && (c <= hi - 1);
            chk({nm, " ramREN"}, 32'(bus_if.ramREN), 32'((in_d && !dw) || in_i));
            chk({nm, " ramWEN"}, 32'(bus_if.ramWEN), 32'(in_d && dw));
            if (in_d || in_i) chk({nm, " ramaddr"}, bus_if.ramaddr, in_d ? da : ia);
            if (in_d && dw) chk({nm, " ramstore"}, bus_if.ramstore, ds);
            chk({nm, " dhit"}, 32'(bus_if.dhit), 32'(c == hd));
            chk({nm, " ihit"}, 32'(bus_if.ihit), 32'(c == hi));
            if (c == hd) chk({nm, " dload"}, bus_if.dload, dl);
            if (c == hi) chk({nm, " iload"}, bus_if.iload, il);
            chk({nm, " busy"}, 32'(busy), 32'(in_d || in_i || c == hd || c == hi));
        end
        drop_reqs();
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, " flags"}, 32'({bus_if.ihit, bus_if.dhit, bus_if.ramREN, bus_if.ramWEN, busy, timeout_err}), 32'h0);
        chk({nm, " iload"}, bus_if.iload, 32'h0);
        chk({nm, " dload"}, bus_if.dload, 32'h0);
        chk({nm, " ramaddr"}, bus_if.ramaddr, 32'h0);
        chk({nm, " ramstore"}, bus_if.ramstore, 32'h0);
    endtask

    initial begin
        nRST = 1'b0; halt = 1'b0;
        drop_reqs();
        bus_if.iaddr = '0; bus_if.daddr = '0; bus_if.dstore = '0;
        bus_if.ramready = 1'b0; bus_if.ramload = '0;
        ram_mem[32'h40] = 32'h8C010004;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs("reset");
        nRST = 1'b1;

        // Reset in the middle of a write grant.
        ram_dead = 1;
        @(posedge CLK); #1;
        bus_if.dWEN = 1'b1; bus_if.daddr = 32'h80; bus_if.dstore = 32'h11112222;
        for (int c = 1; c <= 2; c++) begin
            @(posedge CLK); #1;
            ram_step();
        end
        @(negedge CLK);
        chk("midrst ramWEN before", 32'(bus_if.ramWEN), 32'h1);
        chk("midrst ramaddr before", bus_if.ramaddr, 32'h80);
        #2 nRST = 1'b0;
        #1;
        check_reset_outputs("midrst");
        drop_reqs();
        @(negedge CLK);
        nRST = 1'b1;
        ram_dead = 0;
        @(negedge CLK);
        chk("midrst busy after", 32'(busy), 32'h0);
        chk("midrst ramWEN after", 32'(bus_if.ramWEN), 32'h0);

        // Directed table: ir dr dw ia da ds wd wi hd hi il dl
        tbl[0] = '{1, 0, 0, 32'h40,  32'h0,   32'h0,        0, 0, -1, 2, 32'h8C010004, 32'h0};
        tbl[1] = '{0, 0, 1, 32'h0,   32'h100, 32'hDEADBEEF, 3, 0,  5, -1, 32'h0, 32'h0};
        tbl[2] = '{0, 1, 0, 32'h0,   32'h100, 32'h0,        0, 0,  2, -1, 32'h0, 32'hDEADBEEF};
        tbl[3] = '{1, 1, 0, 32'h40,  32'h100, 32'h0,        1, 2,  3, 8, 32'h8C010004, 32'hDEADBEEF};
        tbl[4] = '{0, 1, 1, 32'h0,   32'h200, 32'h12345678, 0, 0,  2, -1, 32'h0, 32'hDEADBEEF};
        tbl[5] = '{1, 0, 1, 32'h300, 32'h300, 32'hCAFEF00D, 0, 0,  2, 5, 32'hCAFEF00D, 32'hDEADBEEF};
        for (int k = 0; k < 6; k++) begin
            run_case($sformatf("vec%0d", k), tbl[k].ir, tbl[k].dr, tbl[k].dw,
                     tbl[k].ia, tbl[k].da, tbl[k].ds, tbl[k].wd, tbl[k].wi,
                     tbl[k].hd, tbl[k].hi, tbl[k].il, tbl[k].dl);
        end

        @(negedge CLK);
        nRST = 1'b0;
        #1 chk("rst2 dload", bus_if.dload, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        model_dload = 32'h0;

        // Randomized access pairs against the reference model.
        for (int n = 0; n < 40; n++) begin
            bit ir; bit dr; bit dw; int dsel; int s;
            logic [31:0] ia; logic [31:0] da; logic [31:0] ds; logic [31:0] il; logic [31:0] dl;
            int wd; int wi; int hd; int hi;
            ir   = 1'($urandom_range(0, 1));
            dsel = $urandom_range(0, 3);
            if (!ir && dsel == 0) ir = 1;
            dr = (dsel == 1) || (dsel == 3);
            dw = (dsel >= 2);
            ia = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
            da = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
            ds = $urandom;
            wd = $urandom_range(0, 3);
            wi = $urandom_range(0, 3);
            s = 1; hd = -1; hi = -1; il = '0; dl = '0;
            if (dr || dw) begin
                hd = s + wd + 1;
                s  = hd + 2;
                if (dw) begin
                    ref_mem[da] = ds;
                    dl = model_dload;
                end else begin
                    dl = ref_rd(da);
                    model_dload = dl;
                end
            end
            if (ir) begin
                hi = s + wi + 1;
                il = ref_rd(ia);
            end
            run_case("rand", ir, dr, dw, ia, da, ds, wd, wi, hd, hi, il, dl);
        end

        // Timeout with a dead RAM, then a normal access with the flag still set.
        ram_dead = 1;
        run_case("timeout", 0, 1, 0, 32'h0, 32'h500, 32'h0, 4, 0, 6, -1, 32'h0, 32'hBAD1BAD1);
        chk("timeout_err set", 32'(timeout_err), 32'h1);
        ram_dead = 0;
        run_case("post_to", 1, 0, 0, 32'h40, 32'h0, 32'h0, 0, 0, -1, 2, 32'h8C010004, 32'h0);
        chk("timeout_err sticky", 32'(timeout_err), 32'h1);

        // Halt raised during an instruction grant.
        wait_q.delete();
        wait_q.push_back(2);
        @(posedge CLK); #1;
        bus_if.iREN = 1'b1; bus_if.iaddr = 32'h40;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) begin
                @(posedge CLK); #1;
            end
            if (bus_if.ihit) bus_if.iREN = 1'b0;
            if (c == 2) halt = 1'b1;
            ram_step();
            @(negedge CLK);
            chk("halt ihit", 32'(bus_if.ihit), 32'(c == 4));
            chk("halt busy", 32'(busy), 32'(c >= 1 && c <= 4));
            if (c == 4) chk("halt iload", bus_if.iload, 32'h8C010004);
        end
        bus_if.iREN = 1'b1; bus_if.dREN = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK); #1;
            ram_step();
            @(negedge CLK);
            chk("halted enables", 32'({bus_if.ramREN, bus_if.ramWEN, bus_if.ihit, bus_if.dhit, busy}), 32'h0);
        end
        drop_reqs();
        halt = 1'b0;
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        chk("unhalt busy", 32'(busy), 32'h0);
        run_case("unhalt", 1, 0, 0, 32'h40, 32'h0, 32'h0, 0, 0, -1, 2, 32'h8C010004, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
